// File: rtl/mult_pipe_param_pkg.sv
// rtl/mult_pipe_param_pkg.sv - shared encodings and latency helper for the pipelined multiplier
package mult_pipe_param_pkg;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Edge count from accept to out_valid; butterfly alignment delays match this.
    function automatic int lat(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/mult_stage.sv
// rtl/mult_stage.sv - one shift-add cell of the multiplier pipeline
module mult_stage
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    parameter int STAGE = 1
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [2*WIDTH-1:0]   in_pp,
    input  logic [2*WIDTH-1:0]   in_mcand,
    input  logic [WIDTH-1:0]     in_mplier,
    input  logic                 in_neg,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   out_pp,
    output logic [2*WIDTH-1:0]   out_mcand,
    output logic [WIDTH-1:0]     out_mplier,
    output logic                 out_neg,
    output logic [TAG_W-1:0]     out_tag
);

    // in_mcand arrives already shifted by STAGE-1, so the addend needs no barrel shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_pp     <= '0;
            out_mcand  <= '0;
            out_mplier <= '0;
            out_neg    <= 1'b0;
            out_tag    <= '0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (ce)
                out_valid <= in_valid;
            if (ce) begin
                out_pp     <= in_mplier[STAGE-1] ? (in_pp + in_mcand) : in_pp;
                out_mcand  <= in_mcand << 1;
                out_mplier <= in_mplier;
                out_neg    <= in_neg;
                out_tag    <= in_tag;
            end
        end
    end

endmodule

// File: rtl/mult_pipe_param.sv
// rtl/mult_pipe_param.sv - fully pipelined signed/unsigned shift-add multiplier with tag and flush
module mult_pipe_param
    import mult_pipe_param_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     mult_1,
    input  logic [WIDTH-1:0]     mult_2,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [TAG_W-1:0]     out_tag
);

    logic ce;
    assign ce       = !out_valid || out_ready;
    assign in_ready = ce;

    logic             signed_op;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg_flag;

    // Negating the most negative value yields 2^(WIDTH-1), which is still the right unsigned magnitude.
    assign signed_op = (in_signed == MODE_SIGNED);
    assign a_mag     = (signed_op && mult_1[WIDTH-1]) ? -mult_1 : mult_1;
    assign b_mag     = (signed_op && mult_2[WIDTH-1]) ? -mult_2 : mult_2;
    assign neg_flag  = signed_op && (mult_1[WIDTH-1] ^ mult_2[WIDTH-1]);

    logic             s0_valid;
    logic [WIDTH-1:0] s0_a;
    logic [WIDTH-1:0] s0_b;
    logic             s0_neg;
    logic [TAG_W-1:0] s0_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
            s0_neg   <= 1'b0;
            s0_tag   <= '0;
        end else begin
            if (flush)
                s0_valid <= 1'b0;
            else if (ce)
                s0_valid <= in_valid;
            if (ce) begin
                s0_a   <= a_mag;
                s0_b   <= b_mag;
                s0_neg <= neg_flag;
                s0_tag <= in_tag;
            end
        end
    end

    logic [WIDTH:0]                  vld;
    logic [WIDTH:0][2*WIDTH-1:0]     pp;
    logic [WIDTH:0][2*WIDTH-1:0]     mc;
    logic [WIDTH:0][WIDTH-1:0]       mp;
    logic [WIDTH:0]                  ng;
    logic [WIDTH:0][TAG_W-1:0]       tg;

    assign vld[0] = s0_valid;
    assign pp[0]  = '0;
    assign mc[0]  = {{WIDTH{1'b0}}, s0_a};
    assign mp[0]  = s0_b;
    assign ng[0]  = s0_neg;
    assign tg[0]  = s0_tag;

    for (genvar i = 1; i <= WIDTH; i++) begin : g_stage
        mult_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .STAGE (i)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .ce         (ce),
            .flush      (flush),
            .in_valid   (vld[i-1]),
            .in_pp      (pp[i-1]),
            .in_mcand   (mc[i-1]),
            .in_mplier  (mp[i-1]),
            .in_neg     (ng[i-1]),
            .in_tag     (tg[i-1]),
            .out_valid  (vld[i]),
            .out_pp     (pp[i]),
            .out_mcand  (mc[i]),
            .out_mplier (mp[i]),
            .out_neg    (ng[i]),
            .out_tag    (tg[i])
        );
    end

    // The last cell's shifted operands have no consumer.
    logic unused_tail;
    assign unused_tail = ^{mc[WIDTH], mp[WIDTH]};

    // Result only reloads on a real transaction so it stays put across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (ce)
                out_valid <= vld[WIDTH];
            if (ce && vld[WIDTH]) begin
                result  <= ng[WIDTH] ? -pp[WIDTH] : pp[WIDTH];
                out_tag <= tg[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_mult_pipe_param.sv
// tb/tb_mult_pipe_param.sv - directed self-checking bench for mult_pipe_param
module tb_mult_pipe_param;
    import mult_pipe_param_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [7:0]  mult_1;
    logic [7:0]  mult_2;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  out_tag;

    logic        in_valid16;
    logic        in_ready16;
    logic        in_signed16;
    logic [15:0] mult_1_16;
    logic [15:0] mult_2_16;
    logic [0:0]  in_tag16;
    logic        out_valid16;
    logic        out_ready16;
    logic [31:0] result16;
    logic [0:0]  out_tag16;

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];

    always #5 clk = ~clk;

    mult_pipe_param #(.WIDTH(8), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .mult_1(mult_1), .mult_2(mult_2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag)
    );

    mult_pipe_param #(.WIDTH(16), .TAG_W(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_signed(in_signed16),
        .mult_1(mult_1_16), .mult_2(mult_2_16), .in_tag(in_tag16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .out_tag(out_tag16)
    );

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic [15:0] ua;
        logic [15:0] ub;
        if (s) begin
            sa = {{8{a[7]}}, a};
            sb = {{8{b[7]}}, b};
            return 16'(sa * sb);
        end
        ua = {8'h00, a};
        ub = {8'h00, b};
        return 16'(ua * ub);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Records what is accepted/consumed on the coming edge, then advances one cycle.
    task automatic tick();
        if (in_valid && in_ready && !flush)
            exp_q.push_back({in_tag, ref8(mult_1, mult_2, in_signed)});
        if (out_valid && out_ready)
            obs_q.push_back({out_tag, result});
        step();
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] t);
        in_valid  = v;
        in_signed = s;
        mult_1    = a;
        mult_2    = b;
        in_tag    = t;
    endtask

    task automatic test_reset();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_tests++;
        if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result got %h want 0000", result); end
        n_tests++;
        if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_tests++;
        if (out_valid16 !== 1'b0 || result16 !== 32'h0) begin
            n_fail++; $display("FAIL reset_w16 got v=%0b r=%h want v=0 r=0", out_valid16, result16);
        end
    endtask

    task automatic test_unsigned_latency();
        int edges;
        int seen;
        out_ready = 1'b1;
        drive(1'b1, MODE_UNSIGNED, 8'hFF, 8'hFF, 4'h3);
        step();
        drive(1'b0, MODE_UNSIGNED, 8'h00, 8'h00, 4'h0);
        edges = 1;
        seen = 0;
        while (!out_valid && edges < 30) begin
            step();
            edges++;
        end
        seen = out_valid;
        n_tests++;
        if (seen !== 1 || edges !== 10) begin
            n_fail++; $display("FAIL latency8 got edges=%0d valid=%0d want edges=10 valid=1", edges, seen);
        end
        n_tests++;
        if (result !== 16'hFE01 || out_tag !== 4'h3) begin
            n_fail++; $display("FAIL unsigned_255x255 got %h tag %h want fe01 tag 3", result, out_tag);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse got valid=%0b want 0", out_valid); end
    endtask

    task automatic test_signed();
        logic [15:0] want [4];
        logic [19:0] got;
        want[0] = 16'h4000; want[1] = 16'hC080; want[2] = 16'hFF81; want[3] = 16'h0000;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b1;
        drive(1'b1, MODE_SIGNED, 8'h80, 8'h80, 4'h0); tick();
        drive(1'b1, MODE_SIGNED, 8'h80, 8'h7F, 4'h1); tick();
        drive(1'b1, MODE_SIGNED, 8'h7F, 8'hFF, 4'h2); tick();
        drive(1'b1, MODE_SIGNED, 8'h00, 8'hFB, 4'h3); tick();
        drive(1'b0, MODE_UNSIGNED, 8'h00, 8'h00, 4'h0);
        for (int c = 0; c < 20; c++) tick();
        n_tests++;
        if (obs_q.size() != 4) begin n_fail++; $display("FAIL signed_count got %0d want 4", obs_q.size()); end
        for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
            got = obs_q[k];
            n_tests++;
            if (got[15:0] !== want[k] || got[19:16] !== 4'(k)) begin
                n_fail++; $display("FAIL signed_%0d got %h tag %h want %h tag %h", k, got[15:0], got[19:16], want[k], k);
            end
        end
    endtask

    task automatic test_back_to_back();
        int run;
        int best;
        logic [19:0] e;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b1;
        run = 0; best = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'($urandom_range(1)), 8'($urandom), 8'($urandom), 4'(k));
            if (out_valid) run++; else run = 0;
            if (run > best) best = run;
            tick();
        end
        drive(1'b0, MODE_UNSIGNED, 8'h00, 8'h00, 4'h0);
        for (int c = 0; c < 20; c++) begin
            if (out_valid) run++; else run = 0;
            if (run > best) best = run;
            tick();
        end
        n_tests++;
        if (best != 20) begin n_fail++; $display("FAIL b2b_run got %0d want 20", best); end
        n_tests++;
        if (obs_q.size() != 20) begin n_fail++; $display("FAIL b2b_count got %0d want 20", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q[0] !== e) begin
                n_fail++; $display("FAIL b2b_data got %h want %h", obs_q[0], e);
            end
            void'(obs_q.pop_front());
        end
    endtask

    task automatic test_stall();
        logic [15:0] hold_r;
        logic [3:0]  hold_t;
        int c;
        logic [19:0] e;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b0;
        c = 0;
        while (in_ready && c < 30) begin
            drive(1'b1, MODE_UNSIGNED, 8'(c + 3), 8'(2 * c + 1), 4'(c));
            tick();
            c++;
        end
        n_tests++;
        if (exp_q.size() != 10) begin n_fail++; $display("FAIL stall_fill got %0d want 10", exp_q.size()); end
        hold_r = result;
        hold_t = out_tag;
        drive(1'b1, MODE_SIGNED, 8'h55, 8'hAA, 4'hF);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if (in_ready !== 1'b0 || result !== hold_r || out_tag !== hold_t || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold got rdy=%0b r=%h t=%h want rdy=0 r=%h t=%h",
                                   in_ready, result, out_tag, hold_r, hold_t);
            end
        end
        drive(1'b0, MODE_UNSIGNED, 8'h00, 8'h00, 4'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        n_tests++;
        if (obs_q.size() != 10) begin n_fail++; $display("FAIL stall_drain got %0d want 10", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q[0] !== e) begin n_fail++; $display("FAIL stall_data got %h want %h", obs_q[0], e); end
            void'(obs_q.pop_front());
        end
    endtask

    task automatic test_reset_inflight();
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, MODE_UNSIGNED, 8'(k + 10), 8'(k + 20), 4'(k + 4));
            tick();
        end
        drive(1'b0, MODE_UNSIGNED, 8'h00, 8'h00, 4'h0);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || result !== 16'h0 || out_tag !== 4'h0) begin
            n_fail++; $display("FAIL reset_mid got v=%0b r=%h t=%h want 0 0000 0", out_valid, result, out_tag);
        end
        step();
        rst_n = 1'b1;
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 15; k++) tick();
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_stale got %0d results want 0", obs_q.size()); end
    endtask

    task automatic test_flush();
        int edges;
        exp_q.delete(); obs_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, MODE_SIGNED, 8'(k + 1), 8'hF0, 4'(k));
            tick();
        end
        drive(1'b1, MODE_UNSIGNED, 8'h11, 8'h22, 4'h9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, MODE_UNSIGNED, 8'h00, 8'h00, 4'h0);
        for (int k = 0; k < 12; k++) tick();
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL flush_leak got %0d results want 0", obs_q.size()); end

        drive(1'b1, MODE_UNSIGNED, 8'd5, 8'd7, 4'hA);
        step();
        drive(1'b0, MODE_UNSIGNED, 8'h00, 8'h00, 4'h0);
        edges = 1;
        while (!out_valid && edges < 30) begin
            step();
            edges++;
        end
        n_tests++;
        if (edges !== 10 || result !== 16'd35 || out_tag !== 4'hA) begin
            n_fail++; $display("FAIL flush_next got edges=%0d r=%h t=%h want 10 0023 a", edges, result, out_tag);
        end

        exp_q.delete(); obs_q.delete();
        out_ready = 1'b0;
        step();
        for (int k = 0; k < 30 && in_ready; k++) begin
            drive(1'b1, MODE_UNSIGNED, 8'(k), 8'(k), 4'(k));
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, MODE_UNSIGNED, 8'h00, 8'h00, 4'h0);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stalled got valid=%0b want 0", out_valid); end
        out_ready = 1'b1;
        obs_q.delete();
        for (int k = 0; k < 15; k++) tick();
        n_tests++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL flush_stalled_leak got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_width16();
        int edges;
        in_valid16  = 1'b1;
        in_signed16 = MODE_SIGNED;
        mult_1_16   = 16'h8000;
        mult_2_16   = 16'h8000;
        in_tag16    = 1'b1;
        step();
        in_valid16 = 1'b0;
        edges = 1;
        while (!out_valid16 && edges < 40) begin
            step();
            edges++;
        end
        n_tests++;
        if (edges !== 18 || result16 !== 32'h4000_0000 || out_tag16 !== 1'b1) begin
            n_fail++; $display("FAIL w16_signed got edges=%0d r=%h t=%0b want 18 40000000 1", edges, result16, out_tag16);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, MODE_UNSIGNED, 8'h00, 8'h00, 4'h0);
        in_valid16 = 1'b0; in_signed16 = 1'b0; mult_1_16 = '0; mult_2_16 = '0; in_tag16 = '0;
        out_ready16 = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_unsigned_latency();
        test_signed();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        test_flush();
        test_width16();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_pipe_param.md
# mult_pipe_param

Parametrised, fully pipelined shift-add multiplier for the FFT datapath. It is the next generation of the fixed 8×8 unsigned multiplier stage. Each transaction selects signed or unsigned mode and carries a sideband tag. The block accepts one operand pair per cycle under a valid/ready handshake with backpressure, and supports a synchronous flush. It sits between the twiddle/sample fetch logic and the butterfly accumulators.

## Interface
Parameters:
- WIDTH, 8: operand width in bits; must be ≥ 2.
- TAG_W, 4: sideband tag width; must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all in-flight transactions.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept this cycle.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- mult_1  in  WIDTH  multiplicand.
- mult_2  in  WIDTH  multiplier.
- in_tag  in  TAG_W  opaque sideband, returned with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- result  out  2*WIDTH  product; signed if the transaction was signed.
- out_tag  out  TAG_W  tag of the transaction.

## Operation
- **Pipeline:** WIDTH+2 register stages.
  - S0 conditioning: captures |mult_1|, |mult_2|, the sign flag (XOR of operand MSBs when in_signed, else 0) and the tag.
  - S1..SWIDTH: one shift-add cell each. Stage i adds (mult_1 << (i-1)) to the partial product when bit i-1 of the multiplier is 1.
  - S(WIDTH+1) output: two's-complement negates the partial product when the sign flag is set.
- **Magnitude rule:** |−2^(WIDTH−1)| = 2^(WIDTH−1) fits in WIDTH unsigned bits. The partial product is 2*WIDTH bits wide, so no stage overflows.
- **Enable:** a single global advance enable, ce = !out_valid | out_ready. All stages, including the valid bits, shift only when ce = 1.
- **in_ready:** in_ready = ce. It is combinational from out_valid/out_ready, with no path from in_valid.
- **Accept:** a transaction is accepted on an edge where in_valid & in_ready. When in_valid = 0 on an advancing edge, a bubble (valid = 0) enters S0.
- **Stall:** when ce = 0, all registers, including result and out_tag, hold. Inputs are ignored.
- **Flush:** on a flush edge, all valid bits clear regardless of ce, and nothing is accepted that cycle. flush has priority over in_valid. Datapath registers need not clear.
- **Reset:** asynchronous. All valid bits, result and out_tag go to 0. Reset asserted mid-operation discards every in-flight transaction; nothing emerges after release.
- **Ordering:** strict FIFO; the tag always travels with its product.

## Timing
- Latency: a pair accepted at edge k produces out_valid = 1 after edge k+WIDTH+1 when there is no stall; that is WIDTH+2 edges.
- Each stall cycle adds exactly one cycle of latency to every in-flight transaction.
- Throughput: one result per cycle while out_ready = 1.
- Reset values: out_valid = 0, result = 0, out_tag = 0. in_ready = 1 immediately after reset.
- Simultaneous in_valid & out_ready with a full pipe: the oldest result leaves and the new pair enters on the same edge, with no bubble.
- flush & ~out_ready in the same cycle: out_valid = 0 after the edge.

## Structure
- Shared package/include holds:
  - the sign-mode encoding (MODE_UNSIGNED = 0, MODE_SIGNED = 1);
  - the latency function LAT(WIDTH) = WIDTH+2, reused by butterfly alignment delays.
- Sub-module mult_stage: one shift-add cell with parameters WIDTH and STAGE. It registers the partial product, shifted operands, sign flag, tag and valid under ce/flush. It is instantiated WIDTH times in a generate loop.
- S0 conditioning and the output negate stage live in the top module.

## Test plan
1. WIDTH=8, unsigned, 255×255, tag 0x3 -> result 0xFE01, out_tag 0x3, exactly 10 edges after accept.
2. Signed pairs −128×−128, −128×127, 127×−1, 0×−5 -> 0x4000, 0xC080 (−16256), 0xFF81 (−127), 0x0000.
3. 20 back-to-back random pairs with mixed modes, out_ready = 1 -> 20 consecutive out_valid cycles, in order, all matching the reference model.
4. out_ready low for 5 cycles while the pipe is full -> result/out_tag stable, in_ready = 0; no loss or duplication after release.
5. Assert rst_n low while 4 transactions are in flight -> out_valid = 0 immediately; no stale result after release.
6. Pulse flush with 6 in flight plus in_valid = 1 that cycle -> none of those 7 emerge; the next accepted pair returns at normal latency. Repeat with WIDTH=16, TAG_W=1: 0x8000×0x8000 signed -> 0x40000000.
